line_buffer_reader: RTL and testbench

- Read side of the camera ping-pong line buffers; runs on the same pixel clock as the capture logic.
- Detects each line-complete event, i.e. a toggle of the capture side's buffSelect.
- Reads the just-completed buffer (the one capture has stopped writing) from its synchronous-read RAM.
- Streams the pixels downstream as 16-bit words over a valid/ready handshake, with start-of-frame and end-of-line markers.

---
 rtl/line_buffer_reader_if.sv | 25 ++
 rtl/line_buffer_reader.sv | 137 +++++++++++++
 tb/tb_line_buffer_reader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_reader_if.sv
// Line-buffer read port plus downstream pixel stream of the camera line reader.
interface line_buffer_reader_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] rdAddr;
  logic              rdEn1;
  logic              rdEn2;
  logic [15:0]       rdData1;
  logic [15:0]       rdData2;
  logic [15:0]       pixOut;
  logic              pixValid;
  logic              pixReady;
  logic              pixFirst;
  logic              pixLast;

  modport master (
    output rdAddr, rdEn1, rdEn2, pixOut, pixValid, pixFirst, pixLast,
    input  rdData1, rdData2, pixReady
  );

  modport slave (
    input  rdAddr, rdEn1, rdEn2, pixOut, pixValid, pixFirst, pixLast,
    output rdData1, rdData2, pixReady
  );
endinterface

// File: rtl/line_buffer_reader.sv
// Reads the just-completed ping-pong line buffer on each buffSelect toggle and
// streams it as 16-bit pixels with start-of-frame / end-of-line markers.
module line_buffer_reader #(
  parameter int LINE_PIXELS = 640,
  parameter int ADDR_W      = 10
) (
  input  logic                  camPCLK,
  input  logic                  reset,
  input  logic                  camVSYNC,
  input  logic                  buffSelect,
  output logic                  lineDrop,
  line_buffer_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHOW} state_t;

  // One extra address bit so LINE_PIXELS == 2^ADDR_W still has a distinct end value.
  localparam logic [ADDR_W:0] LAST_ADDR  = (ADDR_W+1)'(LINE_PIXELS);
  localparam logic [ADDR_W:0] FIRST_ADDR = (ADDR_W+1)'(1);

  state_t          state, state_nxt;
  logic            bs_prev;
  logic            frame_flag;
  logic            cur_buf;
  logic [ADDR_W:0] addr;
  logic [15:0]     pix_out;
  logic            pix_valid, pix_first, pix_last;
  logic            drop_q;
  logic            line_evt, accept, last_accept, rd_en, drop;

  assign line_evt    = (buffSelect != bs_prev) && !camVSYNC;
  assign accept      = (state == SHOW) && pix_valid && bus.pixReady;
  assign last_accept = accept && pix_last;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    drop      = 1'b0;
    if (camVSYNC) begin
      state_nxt = IDLE;
    end else if (line_evt) begin
      // Capture now overwrites cur_buf; a line that just finished is not a drop.
      state_nxt = FETCH;
      drop      = (state != IDLE) && !last_accept;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        FETCH: begin
          rd_en     = 1'b1;
          state_nxt = LOAD;
        end
        LOAD:  state_nxt = SHOW;
        SHOW: begin
          if (accept) begin
            if (pix_last) begin
              state_nxt = IDLE;
            end else begin
              rd_en     = 1'b1;
              state_nxt = LOAD;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge camPCLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge camPCLK or posedge reset) begin
    if (reset) begin
      bs_prev    <= 1'b0;
      frame_flag <= 1'b1;
      cur_buf    <= 1'b0;
      addr       <= '0;
      pix_out    <= '0;
      pix_valid  <= 1'b0;
      pix_first  <= 1'b0;
      pix_last   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      bs_prev <= buffSelect;
      drop_q  <= drop;
      if (camVSYNC) begin
        pix_valid  <= 1'b0;
        pix_first  <= 1'b0;
        pix_last   <= 1'b0;
        frame_flag <= 1'b1;
      end else if (line_evt) begin
        addr      <= '0;
        cur_buf   <= bs_prev;
        pix_valid <= 1'b0;
        pix_first <= 1'b0;
        pix_last  <= 1'b0;
        if (last_accept) frame_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          FETCH: addr <= addr + 1'b1;
          LOAD: begin
            pix_out   <= cur_buf ? bus.rdData2 : bus.rdData1;
            pix_valid <= 1'b1;
            pix_last  <= (addr == LAST_ADDR);
            pix_first <= frame_flag && (addr == FIRST_ADDR);
          end
          SHOW: begin
            if (accept) begin
              pix_valid  <= 1'b0;
              pix_first  <= 1'b0;
              pix_last   <= 1'b0;
              frame_flag <= 1'b0;
              if (!pix_last) addr <= addr + 1'b1;
            end
          end
          default: begin
            pix_valid <= 1'b0;
            pix_first <= 1'b0;
            pix_last  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rdAddr   = addr[ADDR_W-1:0];
  assign bus.rdEn1    = rd_en && !cur_buf;
  assign bus.rdEn2    = rd_en && cur_buf;
  assign bus.pixOut   = pix_out;
  assign bus.pixValid = pix_valid;
  assign bus.pixFirst = pix_first;
  assign bus.pixLast  = pix_last;
  assign lineDrop     = drop_q;

endmodule

// File: tb/tb_line_buffer_reader.sv
// Scoreboard bench for line_buffer_reader: directed line reads, backpressure,
// VSYNC abort, overrun drop, back-to-back lines and async reset.
module tb_line_buffer_reader;
  localparam int LP = 4;
  localparam int AW = 10;

  logic camPCLK    = 1'b0;
  logic reset      = 1'b1;
  logic camVSYNC   = 1'b0;
  logic buffSelect = 1'b0;
  logic lineDrop;

  line_buffer_reader_if #(.ADDR_W(AW)) bus ();

  line_buffer_reader #(.LINE_PIXELS(LP), .ADDR_W(AW)) dut (
    .camPCLK    (camPCLK),
    .reset      (reset),
    .camVSYNC   (camVSYNC),
    .buffSelect (buffSelect),
    .lineDrop   (lineDrop),
    .bus        (bus)
  );

  always #5 camPCLK = ~camPCLK;

  // Synchronous-read line buffer models with address-tagged contents.
  always @(posedge camPCLK) begin
    if (bus.rdEn1) bus.rdData1 <= 16'hA000 + 16'(bus.rdAddr);
    if (bus.rdEn2) bus.rdData2 <= 16'hB000 + 16'(bus.rdAddr);
  end

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } pix_t;

  pix_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rd1_cnt = 0, rd2_cnt = 0, drop_cnt = 0;
  pix_t held;
  logic held_v = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge camPCLK) begin
    pix_t e;
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (bus.rdEn1) rd1_cnt++;
      if (bus.rdEn2) rd2_cnt++;
      if (lineDrop)  drop_cnt++;
      if (bus.rdEn1 || bus.rdEn2) begin
        check("rden_both", 32'(bus.rdEn1 && bus.rdEn2), 0);
        check("rdaddr_range", 32'(bus.rdAddr < LP), 1);
      end
      if (held_v && bus.pixValid)
        check("hold_stable", 32'({bus.pixOut, bus.pixFirst, bus.pixLast}), 32'(held));
      held_v = bus.pixValid && !bus.pixReady;
      held   = '{bus.pixOut, bus.pixFirst, bus.pixLast};
      if (bus.pixValid && bus.pixReady) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pixel: got %h expected none", bus.pixOut);
        end else begin
          e = exp_q.pop_front();
          check("pix_data", 32'(bus.pixOut), 32'(e.data));
          check("pix_first", 32'(bus.pixFirst), 32'(e.first));
          check("pix_last", 32'(bus.pixLast), 32'(e.last));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge camPCLK);
    #1;
  endtask

  task automatic push_line(input logic [15:0] base, input logic first);
    for (int i = 0; i < LP; i++)
      exp_q.push_back('{base + 16'(i), first && (i == 0), (i == LP-1)});
  endtask

  task automatic wait_show(input logic [15:0] d, input string name);
    int n = 0;
    while (!(bus.pixValid && bus.pixOut == d) && n < 40) begin
      step(1);
      n++;
    end
    check({name, "_valid"}, 32'(bus.pixValid), 1);
    check({name, "_data"}, 32'(bus.pixOut), 32'(d));
  endtask

  task automatic wait_last(input string name);
    int n = 0;
    while (!(bus.pixValid && bus.pixLast) && n < 40) begin
      step(1);
      n++;
    end
    check(name, 32'(bus.pixValid && bus.pixLast), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !bus.pixValid) && n < 80) begin
      step(1);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 0);
    check({name, "_idle"}, 32'(bus.pixValid), 0);
  endtask

  initial begin
    int r1, r2, d;
    bus.pixReady = 1'b0;
    bus.rdData1  = '0;
    bus.rdData2  = '0;
    step(2);
    check("rst_valid", 32'(bus.pixValid), 0);
    check("rst_first", 32'(bus.pixFirst), 0);
    check("rst_last", 32'(bus.pixLast), 0);
    check("rst_drop", 32'(lineDrop), 0);
    check("rst_rden", 32'({bus.rdEn1, bus.rdEn2}), 0);
    check("rst_addr", 32'(bus.rdAddr), 0);
    check("rst_pixout", 32'(bus.pixOut), 0);
    reset = 1'b0;
    step(3);
    check("idle_no_valid", 32'(bus.pixValid), 0);

    // Buffer 1 line, no backpressure
    r2 = rd2_cnt;
    push_line(16'hA000, 1'b1);
    bus.pixReady = 1'b1;
    buffSelect   = 1'b1;
    wait_idle("line_buf1");
    check("buf1_no_rden2", 32'(rd2_cnt - r2), 0);

    // Buffer 2 line, stall on second pixel
    r1 = rd1_cnt;
    r2 = rd2_cnt;
    push_line(16'hB000, 1'b0);
    buffSelect = 1'b0;
    wait_show(16'hB001, "bp_second");
    bus.pixReady = 1'b0;
    step(5);
    bus.pixReady = 1'b1;
    wait_idle("line_buf2");
    check("buf2_rden2_count", 32'(rd2_cnt - r2), LP);
    check("buf2_no_rden1", 32'(rd1_cnt - r1), 0);

    // VSYNC mid-line with buffSelect forced back to 0
    bus.pixReady = 1'b0;
    buffSelect   = 1'b1;
    wait_show(16'hA000, "vs_line");
    d = drop_cnt;
    camVSYNC   = 1'b1;
    buffSelect = 1'b0;
    step(1);
    check("vs_valid_drop", 32'(bus.pixValid), 0);
    bus.pixReady = 1'b1;
    repeat (4) begin
      step(1);
      check("vs_hold_idle", 32'(bus.pixValid), 0);
    end
    camVSYNC = 1'b0;
    repeat (3) begin
      step(1);
      check("vs_no_event", 32'(bus.pixValid), 0);
    end
    check("vs_no_drop", 32'(drop_cnt - d), 0);
    push_line(16'hA000, 1'b1);
    buffSelect = 1'b1;
    wait_idle("vs_next_first");

    // Overrun: stalled on second pixel when the next line completes
    exp_q.push_back('{16'hB000, 1'b0, 1'b0});
    buffSelect = 1'b0;
    wait_show(16'hB001, "ovr_second");
    bus.pixReady = 1'b0;
    step(2);
    d = drop_cnt;
    buffSelect = 1'b1;
    step(1);
    check("ovr_drop_pulse", 32'(lineDrop), 1);
    check("ovr_valid_clear", 32'(bus.pixValid), 0);
    check("ovr_no_last", 32'(bus.pixLast), 0);
    push_line(16'hA000, 1'b0);
    bus.pixReady = 1'b1;
    step(1);
    check("ovr_drop_one_cycle", 32'(lineDrop), 0);
    wait_idle("ovr_restart");
    check("ovr_drop_count", 32'(drop_cnt - d), 1);

    // Back-to-back: toggle coincides with the pixLast accept
    d = drop_cnt;
    push_line(16'hB000, 1'b0);
    buffSelect = 1'b0;
    wait_last("b2b_last");
    push_line(16'hA000, 1'b0);
    buffSelect = 1'b1;
    step(1);
    check("b2b_lat1", 32'(bus.pixValid), 0);
    step(1);
    check("b2b_lat2", 32'(bus.pixValid), 0);
    step(1);
    check("b2b_lat3", 32'(bus.pixValid), 1);
    wait_idle("b2b_line");
    check("b2b_no_drop", 32'(drop_cnt - d), 0);

    // Asynchronous reset while a pixel is on display
    bus.pixReady = 1'b0;
    buffSelect   = 1'b0;
    wait_show(16'hB000, "rst_line");
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus.pixValid), 0);
    check("arst_first", 32'(bus.pixFirst), 0);
    check("arst_last", 32'(bus.pixLast), 0);
    check("arst_pixout", 32'(bus.pixOut), 0);
    check("arst_addr", 32'(bus.rdAddr), 0);
    check("arst_rden", 32'({bus.rdEn1, bus.rdEn2}), 0);
    step(2);
    reset = 1'b0;
    repeat (4) begin
      step(1);
      check("arst_no_valid", 32'(bus.pixValid), 0);
    end
    push_line(16'hA000, 1'b1);
    bus.pixReady = 1'b1;
    buffSelect   = 1'b1;
    wait_idle("post_reset_first");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
